hazard_scoreboard: RTL and testbench

Pipeline hazard controller for the five-stage ARMv8 core. Tracks in-flight register writes for instructions beyond instruction decode (EX, MEM, WB) in a three-entry shadow scoreboard. Stalls PC and IF/ID and injects an ID/EX bubble on read-after-write hazards. Squashes younger instructions when a branch resolves taken in MEM.

---
 rtl/hazard_scoreboard.sv | 164 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Read-after-write hazard controller for the five-stage pipeline. A shadow
// scoreboard mirrors the destination registers of the instructions in EX,
// MEM and WB. The instruction in ID is compared against it. On a hazard the
// block stalls PC and IF/ID and injects an ID/EX bubble. A branch that
// resolves taken in MEM squashes IF/ID, ID/EX and EX/MEM.
//
// Parameters
//   FORWARDING       1: EX/MEM forwarding exists, so only load-use stalls.
//                    0: stall on any RAW against EX or MEM.
//   RF_WRITE_THROUGH 1: a register-file read sees a same-cycle write.
//                    0: a match with the WB entry also stalls.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   id_valid            ID holds a real instruction
//   id_rn, id_rm        source registers (id_rm is taken after the Reg2Loc mux)
//   id_uses_rn/rm       the corresponding source is actually read
//   id_rd               destination register
//   id_reg_write        the instruction writes id_rd
//   id_mem_read         the instruction is a load
//   mem_branch_taken    the branch in MEM resolved taken this cycle
//   pc_write            PC update enable
//   ifid_write          IF/ID register enable
//   ifid_flush          IF/ID becomes a NOP
//   idex_bubble         ID/EX control fields are zeroed
//   exmem_bubble        EX/MEM control fields are zeroed
//   stall_count         saturating count of stall cycles
module hazard_scoreboard #(
    parameter bit FORWARDING       = 1'b1,
    parameter bit RF_WRITE_THROUGH = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rn,
    input  logic [4:0]  id_rm,
    input  logic        id_uses_rn,
    input  logic        id_uses_rm,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        mem_branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        exmem_bubble,
    output logic [31:0] stall_count
);

    localparam logic [4:0]  XZR     = 5'd31;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // Scoreboard entries. The load flag only matters while the producer is
    // in EX, because a load in MEM can already be forwarded. For that reason
    // MEM and WB carry no load flag.
    logic        ex_valid_r;
    logic [4:0]  ex_rd_r;
    logic        ex_load_r;
    logic        mem_valid_r;
    logic [4:0]  mem_rd_r;
    logic        wb_valid_r;
    logic [4:0]  wb_rd_r;
    logic [31:0] stall_count_r;

    logic        rn_hazard_s;
    logic        rm_hazard_s;
    logic        stall_s;
    logic        ex_alloc_s;

    // A used source matches a valid entry. XZR never matches.
    function automatic logic entry_match(
        input logic       used,
        input logic [4:0] src,
        input logic       valid,
        input logic [4:0] rd
    );
        return used & (src != XZR) & valid & (src == rd);
    endfunction

    // Hazard of one source against every entry that matters for this configuration.
    function automatic logic src_hazard(
        input logic       used,
        input logic [4:0] src,
        input logic       exv,
        input logic [4:0] exrd,
        input logic       exld,
        input logic       memv,
        input logic [4:0] memrd,
        input logic       wbv,
        input logic [4:0] wbrd
    );
        logic ex_hit;
        logic mem_hit;
        logic wb_hit;
        ex_hit  = entry_match(used, src, exv, exrd) & (exld | ~FORWARDING);
        mem_hit = entry_match(used, src, memv, memrd) & ~FORWARDING;
        wb_hit  = entry_match(used, src, wbv, wbrd) & ~RF_WRITE_THROUGH;
        return ex_hit | mem_hit | wb_hit;
    endfunction

    // Detect hazards. A taken branch overrides the stall because the stalled instruction is squashed.
    always_comb begin
        rn_hazard_s = src_hazard(id_uses_rn, id_rn, ex_valid_r, ex_rd_r, ex_load_r,
                                 mem_valid_r, mem_rd_r, wb_valid_r, wb_rd_r);
        rm_hazard_s = src_hazard(id_uses_rm, id_rm, ex_valid_r, ex_rd_r, ex_load_r,
                                 mem_valid_r, mem_rd_r, wb_valid_r, wb_rd_r);
        stall_s     = id_valid & (rn_hazard_s | rm_hazard_s) & ~mem_branch_taken;
        ex_alloc_s  = id_valid & id_reg_write & (id_rd != XZR) & ~stall_s & ~mem_branch_taken;
    end

    // Drive the pipeline controls. While reset is held, the pipeline is frozen and flushed.
    always_comb begin
        if (reset) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end else begin
            pc_write     = ~stall_s;
            ifid_write   = ~stall_s;
            ifid_flush   = mem_branch_taken;
            idex_bubble  = stall_s | mem_branch_taken;
            exmem_bubble = mem_branch_taken;
        end
    end

    // Advance the scoreboard with the pipeline. Squashed instructions leave no entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid_r  <= 1'b0;
            ex_rd_r     <= 5'd0;
            ex_load_r   <= 1'b0;
            mem_valid_r <= 1'b0;
            mem_rd_r    <= 5'd0;
            wb_valid_r  <= 1'b0;
            wb_rd_r     <= 5'd0;
        end else begin
            wb_valid_r  <= mem_valid_r;
            wb_rd_r     <= mem_rd_r;
            mem_valid_r <= ex_valid_r & ~mem_branch_taken;
            mem_rd_r    <= ex_rd_r;
            ex_valid_r  <= ex_alloc_s;
            ex_rd_r     <= id_rd;
            ex_load_r   <= id_mem_read & ex_alloc_s;
        end
    end

    // Count stall cycles, holding at the maximum value.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count_r <= 32'd0;
        end else if (stall_s && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + 32'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven bench for hazard_scoreboard. It uses three instances that
// share one input bundle:
//   - instance 0 uses the default parameters;
//   - instance 1 sets FORWARDING=0;
//   - instance 2 sets RF_WRITE_THROUGH=0.
// Each table row is one clock cycle. A row gives the inputs and the expected
// outputs of the instance that the row targets. Every phase starts with
// reset, so the instances that a phase does not check can take any stimulus.
module tb_hazard_scoreboard;

    typedef struct {
        int          which;
        logic        rst;
        logic        br;
        logic        valid;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic        urn;
        logic        urm;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        exp_pc;
        logic        exp_bub;
        logic        exp_fl;
        logic        chk_cnt;
        logic [31:0] exp_cnt;
    } vec_t;

    typedef struct {
        string       name;
        int          which;
        logic [4:0]  ctl;
        logic        chk_cnt;
        logic [31:0] cnt;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rn;
    logic [4:0]  id_rm;
    logic        id_uses_rn;
    logic        id_uses_rm;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        mem_branch_taken;

    logic        pc_write_o     [3];
    logic        ifid_write_o   [3];
    logic        ifid_flush_o   [3];
    logic        idex_bubble_o  [3];
    logic        exmem_bubble_o [3];
    logic [31:0] stall_count_o  [3];

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_checks;
    int   n_pass;

    hazard_scoreboard #(.FORWARDING(1'b1), .RF_WRITE_THROUGH(1'b1)) dut0 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .mem_branch_taken(mem_branch_taken), .pc_write(pc_write_o[0]),
        .ifid_write(ifid_write_o[0]), .ifid_flush(ifid_flush_o[0]),
        .idex_bubble(idex_bubble_o[0]), .exmem_bubble(exmem_bubble_o[0]),
        .stall_count(stall_count_o[0]));

    hazard_scoreboard #(.FORWARDING(1'b0), .RF_WRITE_THROUGH(1'b1)) dut1 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .mem_branch_taken(mem_branch_taken), .pc_write(pc_write_o[1]),
        .ifid_write(ifid_write_o[1]), .ifid_flush(ifid_flush_o[1]),
        .idex_bubble(idex_bubble_o[1]), .exmem_bubble(exmem_bubble_o[1]),
        .stall_count(stall_count_o[1]));

    hazard_scoreboard #(.FORWARDING(1'b1), .RF_WRITE_THROUGH(1'b0)) dut2 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .mem_branch_taken(mem_branch_taken), .pc_write(pc_write_o[2]),
        .ifid_write(ifid_write_o[2]), .ifid_flush(ifid_flush_o[2]),
        .idex_bubble(idex_bubble_o[2]), .exmem_bubble(exmem_bubble_o[2]),
        .stall_count(stall_count_o[2]));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Append one row. The row order is: target, reset, branch, instruction fields,
    // then the expected pc_write, idex_bubble and flush, and optionally the count.
    task automatic add(input int w, input logic rst, input logic br, input logic v,
                       input int rn, input int rm, input logic urn, input logic urm,
                       input int rd, input logic rw, input logic mr,
                       input logic pc, input logic bub, input logic fl,
                       input logic cc, input int cnt);
        vec_t t;
        t.which = w;  t.rst = rst;  t.br = br;  t.valid = v;
        t.rn = 5'(rn);  t.rm = 5'(rm);  t.urn = urn;  t.urm = urm;
        t.rd = 5'(rd);  t.rw = rw;  t.mr = mr;
        t.exp_pc = pc;  t.exp_bub = bub;  t.exp_fl = fl;
        t.chk_cnt = cc;  t.exp_cnt = 32'(cnt);
        vecs.push_back(t);
    endtask

    task automatic nop(input int w, input int cnt);
        add(w, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, cnt);
    endtask

    task automatic do_reset(input int w);
        add(w, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        add(w, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        nop(w, 0);
    endtask

    initial begin
        logic [4:0]  act_ctl;
        logic [31:0] act_cnt;
        exp_t        e;

        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1;  id_valid = 1'b0;  id_rn = 5'd0;  id_rm = 5'd0;
        id_uses_rn = 1'b0;  id_uses_rm = 1'b0;  id_rd = 5'd0;
        id_reg_write = 1'b0;  id_mem_read = 1'b0;  mem_branch_taken = 1'b0;

        // Phase 0: default parameters.
        do_reset(0);
        add(0,0,0,1, 1,0,1,0, 2,1,1,  1,0,0, 1,0);  // LDUR X2,[X1]
        add(0,0,0,1, 2,4,1,1, 3,1,0,  0,1,0, 1,0);  // ADD X3,X2,X4: load-use stall
        add(0,0,0,1, 2,4,1,1, 3,1,0,  1,0,0, 1,1);  // same ADD, now free
        nop(0, 1);
        add(0,0,0,1, 1,1,1,1, 2,1,0,  1,0,0, 1,1);  // ADD X2,X1,X1
        add(0,0,0,1, 2,1,1,1, 5,1,0,  1,0,0, 1,1);  // SUB X5,X2,X1: forwarded
        add(0,0,0,1, 1,0,1,0, 6,1,1,  1,0,0, 1,1);  // LDUR X6
        add(0,0,1,1, 6,0,1,0, 7,1,1,  1,1,1, 1,1);  // LDUR X7,[X6] + taken branch
        add(0,0,0,1, 7,1,1,1, 8,1,0,  1,0,0, 1,1);  // ADD X8,X7,X1: X7 was squashed
        add(0,0,0,1, 1,0,1,0, 31,1,1, 1,0,0, 1,1);  // LDUR X31
        add(0,0,0,1, 31,4,1,1, 3,1,0, 1,0,0, 1,1);  // ADD X3,X31,X4
        add(0,0,0,1, 1,0,1,0, 8,1,1,  1,0,0, 1,1);  // LDUR X8
        add(0,0,0,1, 1,8,1,0, 9,1,0,  1,0,0, 1,1);  // rm=X8 not used
        add(0,0,0,1, 1,0,1,0, 10,1,1, 1,0,0, 1,1);  // LDUR X10
        add(0,0,0,1, 0,10,1,1, 11,1,0, 0,1,0, 1,1); // rm hazard
        add(0,0,0,1, 0,10,1,1, 11,1,0, 1,0,0, 1,2);
        add(0,0,0,1, 1,0,1,0, 12,1,1, 1,0,0, 1,2);  // LDUR X12
        add(0,0,0,1, 12,0,1,0, 13,1,0, 0,1,0, 1,2); // stall ...
        add(0,1,0,1, 12,0,1,0, 13,1,0, 0,1,1, 1,3); // ... then reset mid-stall
        add(0,0,0,1, 12,0,1,0, 13,1,0, 1,0,0, 1,0); // no stall survives reset
        add(0,0,0,1, 1,0,1,0, 14,1,1, 1,0,0, 1,0);  // LDUR X14
        add(0,0,0,0, 14,0,1,0, 15,1,0, 1,0,0, 1,0); // id_valid=0: no stall
        add(0,0,0,1, 1,0,1,0, 16,1,1, 1,0,0, 1,0);  // LDUR X16
        add(0,0,0,1, 16,0,1,0, 17,1,0, 0,1,0, 1,0); // valid dependent stalls
        nop(0, 1);

        // Phase 1: no forwarding.
        do_reset(1);
        add(1,0,0,1, 1,1,1,1, 2,1,0,  1,0,0, 1,0);  // ADD X2
        add(1,0,0,1, 2,1,1,1, 5,1,0,  0,1,0, 1,0);  // SUB X5,X2,X1: EX match
        add(1,0,0,1, 2,1,1,1, 5,1,0,  0,1,0, 1,1);  // MEM match
        add(1,0,0,1, 2,1,1,1, 5,1,0,  1,0,0, 1,2);  // WB, written through
        nop(1, 2);
        add(1,0,0,1, 1,1,1,1, 4,1,0,  1,0,0, 1,2);  // ADD X4
        add(1,0,1,0, 0,0,0,0, 0,0,0,  1,1,1, 1,2);  // taken branch squashes X4 in EX
        add(1,0,0,1, 4,0,1,0, 6,1,0,  1,0,0, 1,2);  // X4 no longer tracked

        // Phase 2: no write-through.
        do_reset(2);
        add(2,0,0,1, 1,1,1,1, 7,1,0,  1,0,0, 1,0);  // ADD X7
        nop(2, 0);
        nop(2, 0);
        add(2,0,0,1, 1,7,1,1, 0,0,0,  0,1,0, 1,0);  // STUR X7,[X1]: WB match
        add(2,0,0,1, 1,7,1,1, 0,0,0,  1,0,0, 1,1);
        nop(2, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clock);
            #1;
            reset = vecs[i].rst;  mem_branch_taken = vecs[i].br;
            id_valid = vecs[i].valid;  id_rn = vecs[i].rn;  id_rm = vecs[i].rm;
            id_uses_rn = vecs[i].urn;  id_uses_rm = vecs[i].urm;  id_rd = vecs[i].rd;
            id_reg_write = vecs[i].rw;  id_mem_read = vecs[i].mr;
            e.name    = $sformatf("row%0d_dut%0d", i, vecs[i].which);
            e.which   = vecs[i].which;
            e.ctl     = {vecs[i].exp_pc, vecs[i].exp_pc, vecs[i].exp_fl,
                         vecs[i].exp_bub, vecs[i].exp_fl};
            e.chk_cnt = vecs[i].chk_cnt;
            e.cnt     = vecs[i].exp_cnt;
            exp_q.push_back(e);

            @(negedge clock);
            e = exp_q.pop_front();
            act_ctl = {pc_write_o[e.which], ifid_write_o[e.which], ifid_flush_o[e.which],
                       idex_bubble_o[e.which], exmem_bubble_o[e.which]};
            act_cnt = stall_count_o[e.which];
            n_checks++;
            if (act_ctl === e.ctl) begin
                n_pass++;
            end else begin
                $display("FAIL %s ctl{pcw,ifidw,flush,idexb,exmemb} got %b want %b",
                         e.name, act_ctl, e.ctl);
            end
            if (e.chk_cnt) begin
                n_checks++;
                if (act_cnt === e.cnt) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s stall_count got %0d want %0d", e.name, act_cnt, e.cnt);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
